// File: rtl/truth_table_sweeper.sv
// Steps a 4-input combinational block through all 16 input vectors, holding each
// for SETTLE cycles, and captures its single output into a 16-bit truth table.
module truth_table_sweeper #(
    parameter int SETTLE = 2
) (
    input  logic        Clock,
    input  logic        Reset_b,
    input  logic        Start,
    input  logic        Abort,
    input  logic        F_in,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    output logic        Busy,
    output logic        Done,
    output logic [15:0] Table,
    output logic [4:0]  Ones
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] LAST_HOLD = 4'(SETTLE - 1);

    state_t      state_r, state_s;
    logic [3:0]  vec_r, vec_s;
    logic [3:0]  cnt_r, cnt_s;
    logic [15:0] table_r, table_s;
    logic [4:0]  ones_r, ones_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;

    // Next-state and next-output computation; Busy/Done are derived from the next
    // state so they can be registered alongside it.
    always_comb begin
        state_s = state_r;
        vec_s   = vec_r;
        cnt_s   = cnt_r;
        table_s = table_r;
        ones_s  = ones_r;
        case (state_r)
            IDLE: begin
                if (Start) begin
                    table_s = 16'h0000;
                    ones_s  = 5'd0;
                    vec_s   = 4'd0;
                    cnt_s   = 4'd0;
                    state_s = APPLY;
                end else begin
                    vec_s   = 4'd0;
                end
            end
            APPLY: begin
                if (Abort) begin
                    vec_s   = 4'd0;
                    cnt_s   = 4'd0;
                    state_s = IDLE;
                end else if (cnt_r == LAST_HOLD) begin
                    cnt_s   = 4'd0;
                    state_s = SAMPLE;
                end else begin
                    cnt_s   = cnt_r + 4'd1;
                end
            end
            SAMPLE: begin
                // Abort wins over the capture: the in-flight sample is discarded.
                if (Abort) begin
                    vec_s   = 4'd0;
                    cnt_s   = 4'd0;
                    state_s = IDLE;
                end else begin
                    table_s[vec_r] = F_in;
                    ones_s         = ones_r + {4'd0, F_in};
                    if (vec_r == 4'd15) begin
                        state_s = DONE;
                    end else begin
                        vec_s   = vec_r + 4'd1;
                        state_s = APPLY;
                    end
                end
            end
            DONE: begin
                vec_s   = 4'd0;
                state_s = IDLE;
            end
            default: begin
                vec_s   = 4'd0;
                cnt_s   = 4'd0;
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s == APPLY) || (state_s == SAMPLE);
        done_s = (state_s == DONE);
    end

    // State, vector, settle counter and result registers.
    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            state_r <= IDLE;
            vec_r   <= 4'd0;
            cnt_r   <= 4'd0;
            table_r <= 16'h0000;
            ones_r  <= 5'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            vec_r   <= vec_s;
            cnt_r   <= cnt_s;
            table_r <= table_s;
            ones_r  <= ones_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign {A, B, C, D} = vec_r;
    assign Busy         = busy_r;
    assign Done         = done_r;
    assign Table        = table_r;
    assign Ones         = ones_r;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: three sweepers (SETTLE = 2, 1, 15) driven by bench-side truth
// tables; expected tables/timing are queued at Start and checked when Done pulses.
module tb_truth_table_sweeper;

    localparam int NI = 3;

    typedef struct {
        int          inst;
        logic [15:0] tbl;
        logic [4:0]  ones;
        int          done_cyc;
    } exp_t;

    logic        Clock = 1'b0;
    logic        Reset_b;
    logic        start_s [NI];
    logic        abort_s [NI];
    logic        a_s     [NI];
    logic        b_s     [NI];
    logic        c_s     [NI];
    logic        d_s     [NI];
    logic        busy_s  [NI];
    logic        done_s  [NI];
    logic [15:0] table_s [NI];
    logic [4:0]  ones_s  [NI];
    logic [15:0] tt      [NI];
    bit          noise_en[NI];
    int          k0      [NI];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    exp_t        q[$];

    function automatic int settle_of(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 1 : 15);
    endfunction

    // Truth table of (A^B)&(C|~D), with A the MSB of the vector index.
    function automatic logic [15:0] func_tt();
        logic [15:0] t;
        logic [3:0]  v;
        t = 16'h0000;
        for (int n = 0; n < 16; n++) begin
            v    = 4'(n);
            t[n] = (v[3] ^ v[2]) & (v[1] | ~v[0]);
        end
        return t;
    endfunction

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int ST = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
        logic       f_l;
        logic [3:0] vec_l;
        int         hold_cnt;
        logic [3:0] prev_vec;
        logic       prev_busy;

        truth_table_sweeper #(.SETTLE(ST)) u_dut (
            .Clock  (Clock),
            .Reset_b(Reset_b),
            .Start  (start_s[g]),
            .Abort  (abort_s[g]),
            .F_in   (f_l),
            .A      (a_s[g]),
            .B      (b_s[g]),
            .C      (c_s[g]),
            .D      (d_s[g]),
            .Busy   (busy_s[g]),
            .Done   (done_s[g]),
            .Table  (table_s[g]),
            .Ones   (ones_s[g])
        );

        // Circuit-under-sweep model; optionally glitches F_in early in each hold window.
        initial begin
            f_l       = 1'b0;
            hold_cnt  = 0;
            prev_vec  = 4'd0;
            prev_busy = 1'b0;
            forever begin
                @(negedge Clock);
                vec_l = {a_s[g], b_s[g], c_s[g], d_s[g]};
                if (!busy_s[g] || !prev_busy || (vec_l != prev_vec)) hold_cnt = 0;
                else hold_cnt++;
                prev_busy = busy_s[g];
                prev_vec  = vec_l;
                if (noise_en[g] && busy_s[g] && (hold_cnt < ST - 1)) f_l = 1'($urandom);
                else f_l = tt[g][vec_l];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, required %0h", nm, cyc, act, req);
        end
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge Clock);
    endtask

    task automatic push_exp(input int i, input logic [15:0] t, input int dcyc);
        exp_t e;
        e.inst     = i;
        e.tbl      = t;
        e.ones     = 5'($countones(t));
        e.done_cyc = dcyc;
        q.push_back(e);
    endtask

    task automatic begin_sweep(input int i, input logic [15:0] t, input bit expect_done);
        tt[i] = t;
        @(negedge Clock);
        start_s[i] = 1'b1;
        k0[i]      = cyc + 1;
        if (expect_done) push_exp(i, t, k0[i] + 16 * (settle_of(i) + 1));
        @(negedge Clock);
        start_s[i] = 1'b0;
    endtask

    task automatic full_sweep(input int i, input logic [15:0] t);
        begin_sweep(i, t, 1'b1);
        wait_until(k0[i] + 16 * (settle_of(i) + 1) + 2);
    endtask

    task automatic abort_sweep(input int i, input logic [15:0] t, input int r);
        logic [15:0] m;
        begin_sweep(i, t, 1'b0);
        wait_until(k0[i] + (r + 1) * (settle_of(i) + 1) - 1);
        abort_s[i] = 1'b1;
        @(negedge Clock);
        abort_s[i] = 1'b0;
        m = t & 16'((32'd1 << r) - 32'd1);
        chk("abort_busy", 32'(busy_s[i]), 32'd0);
        chk("abort_done", 32'(done_s[i]), 32'd0);
        chk("abort_vec", 32'({a_s[i], b_s[i], c_s[i], d_s[i]}), 32'd0);
        chk("abort_table", 32'(table_s[i]), 32'(m));
        chk("abort_ones", 32'(ones_s[i]), 32'($countones(m)));
        repeat (3) @(negedge Clock);
    endtask

    task automatic chk_all_reset(input string nm);
        for (int i = 0; i < NI; i++) begin
            chk({nm, "_vec"}, 32'({a_s[i], b_s[i], c_s[i], d_s[i]}), 32'd0);
            chk({nm, "_busy"}, 32'(busy_s[i]), 32'd0);
            chk({nm, "_done"}, 32'(done_s[i]), 32'd0);
            chk({nm, "_table"}, 32'(table_s[i]), 32'd0);
            chk({nm, "_ones"}, 32'(ones_s[i]), 32'd0);
        end
    endtask

    // Monitor: vector timing on every busy cycle; scoreboard pop on every Done.
    initial begin
        int   busy_cnt[NI];
        exp_t e;
        for (int i = 0; i < NI; i++) busy_cnt[i] = 0;
        forever begin
            @(negedge Clock);
            for (int i = 0; i < NI; i++) begin
                if (done_s[i] === 1'b1) begin
                    if (q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_done inst %0d (cycle %0d): got Done=1, required Done=0", i, cyc);
                    end else begin
                        e = q.pop_front();
                        chk("done_inst", i, e.inst);
                        chk("table", 32'(table_s[i]), 32'(e.tbl));
                        chk("ones", 32'(ones_s[i]), 32'(e.ones));
                        chk("done_cycle", cyc, e.done_cyc);
                        chk("busy_cycles", busy_cnt[i], 16 * (settle_of(i) + 1));
                        chk("busy_in_done", 32'(busy_s[i]), 32'd0);
                    end
                    busy_cnt[i] = 0;
                end else if (busy_s[i] === 1'b1) begin
                    busy_cnt[i]++;
                    chk("vector", 32'({a_s[i], b_s[i], c_s[i], d_s[i]}),
                        (cyc - k0[i]) / (settle_of(i) + 1));
                end else begin
                    busy_cnt[i] = 0;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, required normal end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] t;
        int          e_edge;
        int          r;
        Reset_b = 1'b0;
        for (int i = 0; i < NI; i++) begin
            start_s[i]  = 1'b0;
            abort_s[i]  = 1'b0;
            tt[i]       = 16'h0000;
            noise_en[i] = 1'b0;
            k0[i]       = 0;
        end
        repeat (2) @(negedge Clock);
        chk_all_reset("reset");
        Reset_b = 1'b1;
        repeat (2) @(negedge Clock);

        // Reference function, SETTLE = 2.
        full_sweep(0, func_tt());
        chk("func_table", 32'(table_s[0]), 32'h0DD0);
        chk("func_ones", 32'(ones_s[0]), 32'd6);

        // All-ones then all-zeros, SETTLE = 1.
        full_sweep(1, 16'hFFFF);
        chk("sat_table", 32'(table_s[1]), 32'hFFFF);
        chk("sat_ones", 32'(ones_s[1]), 32'd16);
        full_sweep(1, 16'h0000);
        chk("zero_table", 32'(table_s[1]), 32'd0);
        chk("zero_ones", 32'(ones_s[1]), 32'd0);

        // Abort in the SAMPLE cycle of vector 5.
        abort_sweep(0, 16'hFFFF, 5);

        // Randomised tables and abort points.
        for (int n = 0; n < 4; n++) full_sweep(0, 16'($urandom));
        for (int n = 0; n < 3; n++) full_sweep(1, 16'($urandom));
        for (int n = 0; n < 4; n++) begin
            r = int'($urandom_range(15, 0));
            abort_sweep(0, 16'($urandom), r);
        end

        // Start held high: one sweep per Done, restart two edges after the Done edge.
        t = 16'($urandom);
        tt[0] = t;
        @(negedge Clock);
        start_s[0] = 1'b1;
        k0[0]      = cyc + 1;
        push_exp(0, t, k0[0] + 48);
        e_edge = k0[0] + 48;
        wait_until(e_edge + 1);
        chk("held_start_idle", 32'(busy_s[0]), 32'd0);
        k0[0] = e_edge + 2;
        push_exp(0, t, k0[0] + 48);
        wait_until(e_edge + 2);
        start_s[0] = 1'b0;
        chk("held_start_restart", 32'(busy_s[0]), 32'd1);
        wait_until(k0[0] + 48 + 2);

        // Start only during the Done cycle is ignored.
        begin_sweep(0, 16'($urandom), 1'b1);
        e_edge = k0[0] + 48;
        wait_until(e_edge);
        start_s[0] = 1'b1;
        @(negedge Clock);
        start_s[0] = 1'b0;
        wait_until(e_edge + 3);
        chk("done_start_ignored", 32'(busy_s[0]), 32'd0);
        wait_until(e_edge + 6);
        chk("done_start_ignored2", 32'(busy_s[0]), 32'd0);

        // SETTLE = 15 with F_in glitching during the first 14 hold cycles.
        noise_en[2] = 1'b1;
        full_sweep(2, 16'($urandom));
        full_sweep(2, 16'($urandom));
        noise_en[2] = 1'b0;

        // Asynchronous reset mid-sweep: immediate clear, no Done.
        begin_sweep(0, 16'hFFFF, 1'b0);
        wait_until(k0[0] + 20);
        #2;
        Reset_b = 1'b0;
        #1;
        chk_all_reset("async_reset");
        @(negedge Clock);
        Reset_b = 1'b1;
        repeat (10) @(negedge Clock);

        chk("pending_done", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequential stimulus-and-capture stage for 4-input combinational blocks.
- Upstream side: on Start, drives all 16 input combinations onto A, B, C, D in ascending order, holding each for a programmable settle time.
- Downstream side: samples the block's single output F_in after each settle time and builds the 16-bit truth table plus a ones-count.
- Placement: wraps any 4-input/1-output combinational exercise circuit, so its function can be read out as one word.

## Interface
Parameters:
- SETTLE, 2, hold cycles per vector before sampling F_in; legal range 1..15.

Ports:
- Clock  input  1  sole clock; all state updates on the rising edge.
- Reset_b  input  1  asynchronous, active-low reset.
- Start  input  1  begin a sweep; sampled only in IDLE.
- Abort  input  1  cancel a sweep in progress; sampled in APPLY and SAMPLE.
- F_in  input  1  output of the circuit under sweep.
- A, B, C, D  output  1 each  applied vector; {A,B,C,D} = Vec[3:0], A is the MSB.
- Busy  output  1  high in APPLY and SAMPLE.
- Done  output  1  one-cycle pulse when a sweep completes.
- Table  output  16  Table[v] = F_in sampled while Vec = v.
- Ones  output  5  number of 1 bits in Table, range 0..16.

## Operation
- Reset (Reset_b = 0, takes effect immediately, independent of Clock):
  - State = IDLE.
  - Vec = 0, settle counter = 0, Table = 16'h0000, Ones = 0, Busy = 0, Done = 0.
- All outputs are registered. A, B, C, D change only on clock edges, so they are glitch-free.
- State machine:
  - IDLE, Start = 1: Table ← 0, Ones ← 0, Vec ← 0, settle counter ← 0, go to APPLY.
  - IDLE, Start = 0: stay; Table and Ones hold their previous results.
  - APPLY: settle counter increments every cycle. When the counter equals SETTLE-1, go to SAMPLE and clear the counter.
  - SAMPLE: Table[Vec] ← F_in; Ones ← Ones + F_in.
    - If Vec = 15: go to DONE; Vec stays at 15.
    - Otherwise: Vec ← Vec + 1, go to APPLY.
  - DONE: Done = 1 for this cycle only, then go to IDLE. Vec returns to 0 on entry to IDLE.
- Abort (APPLY or SAMPLE only):
  - Go to IDLE, Vec ← 0, Done stays 0.
  - Table and Ones keep the partial results; the sample in that cycle is not written.
  - Abort has priority over SAMPLE's write.
- Start outside IDLE (including in DONE) is ignored.
- Abort in IDLE or DONE is ignored.
- Ones arithmetic:
  - 5-bit unsigned, no wrap; the maximum reachable value is 16.
  - It always equals the popcount of Table and is incremented only in SAMPLE.
- Vec does not wrap from 15 to 0 inside a sweep; the sweep terminates at 15.

## Timing
- Let edge k0 be the rising edge at which Start = 1 is sampled in IDLE.
- Cycle following k0: Busy = 1, {A,B,C,D} = 0000.
- Vector v is applied from edge k0 + v·(SETTLE+1) and sampled at edge k0 + (v+1)·(SETTLE+1).
- F_in must be stable for SETTLE cycles after Vec changes.
- Sweep length: 16·(SETTLE+1) cycles.
- Done is high in the cycle after edge k0 + 16·(SETTLE+1); Busy is low in that same cycle.
- Table and Ones are final when Done is high.
- Earliest restart: Start sampled at the edge ending the Done cycle is ignored (state is still DONE). The next Start is accepted one cycle later, in IDLE.
- Abort latency: one edge. Busy is low in the cycle after Abort is sampled.
- Reset mid-sweep: all outputs reach their reset values asynchronously. No Done pulse is generated.

## Test plan
- Reset: assert Reset_b = 0 mid-cycle during a sweep → A..D = 0, Busy = 0, Done = 0, Table = 16'h0000, Ones = 0 immediately, with no clock edge required.
- Full sweep: SETTLE = 2, F_in driven by a bench model of (A^B)&(C|~D) → Done pulses exactly 48 cycles after the Start edge, Table = 16'h0DD0, Ones = 6, Busy high for exactly 48 cycles.
- Width/saturation: F_in tied to 1, SETTLE = 1 → Table = 16'hFFFF, Ones = 16 (5'b10000), Done 32 cycles after Start; then F_in tied to 0 and restart → Table = 0, Ones = 0.
- Abort:
  - Setup: SETTLE = 2, F_in = 1; Abort asserted in the SAMPLE cycle of Vec = 5.
  - Required: Table = 16'h001F, Ones = 5, no Done pulse, Busy low the next cycle, Vec = 0.
- Ignored Start:
  - Start held high continuously through a sweep → only one sweep per Done; the next sweep begins exactly 2 cycles after the Done cycle's rising edge.
  - Start = 1 in the Done cycle alone → no new sweep.
- SETTLE = 15:
  - Vector 3 is sampled at edge k0 + 64; Done comes at k0 + 256.
  - Changing F_in during the first 14 hold cycles of a vector has no effect on Table.
